// File: rtl/multsub_ci_pipe.sv
// Multi-lane 3-stage signed multiply/subtract pipeline with chain-in, per-lane
// accumulator and saturating or wrapping result reduction.
module multsub_ci_pipe #(
  parameter int DATA_W  = 18,
  parameter int CHAIN_W = 48,
  parameter int LANES   = 4,
  parameter int SAT_EN  = 1
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       ena,
  input  logic                       in_valid,
  input  logic [1:0]                 mode,
  input  logic [LANES*DATA_W-1:0]    mult_a,
  input  logic [LANES*DATA_W-1:0]    mult_b,
  input  logic [LANES*CHAIN_W-1:0]   chainin,
  output logic                       out_valid,
  output logic [LANES*CHAIN_W-1:0]   result,
  output logic [LANES-1:0]           sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = CHAIN_W + 2;

  if (CHAIN_W < 2 * DATA_W + 1) begin : g_bad_width
    $error("multsub_ci_pipe: CHAIN_W must be at least 2*DATA_W+1");
  end

  // Reduce an extended sum to CHAIN_W bits; bit CHAIN_W of the return is the flag.
  function automatic logic [CHAIN_W:0] reduce_f(input logic signed [EXT_W-1:0] sum);
    logic signed [EXT_W-1:0] max_ext;
    logic signed [EXT_W-1:0] min_ext;
    logic signed [EXT_W-1:0] wrap_ext;
    logic [CHAIN_W:0]        ret;
    max_ext  = {3'b000, {(CHAIN_W-1){1'b1}}};
    min_ext  = {3'b111, {(CHAIN_W-1){1'b0}}};
    wrap_ext = {{2{sum[CHAIN_W-1]}}, sum[CHAIN_W-1:0]};
    if (SAT_EN != 0) begin
      if (sum > max_ext) begin
        ret = {1'b1, max_ext[CHAIN_W-1:0]};
      end else if (sum < min_ext) begin
        ret = {1'b1, min_ext[CHAIN_W-1:0]};
      end else begin
        ret = {1'b0, sum[CHAIN_W-1:0]};
      end
    end else begin
      ret = {(wrap_ext != sum), sum[CHAIN_W-1:0]};
    end
    return ret;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  // Reset synchroniser: asserts immediately, releases on the second clk edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  logic       v1_q;
  logic       v2_q;
  logic       out_valid_q;
  logic [1:0] mode1_q;
  logic [1:0] mode2_q;

  // Shared control pipeline: valid and mode travel alongside the lane data.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      mode1_q     <= 2'b00;
      mode2_q     <= 2'b00;
    end else if (ena) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      mode1_q     <= mode;
      mode2_q     <= mode1_q;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0]  a1_q;
    logic signed [DATA_W-1:0]  b1_q;
    logic signed [CHAIN_W-1:0] c1_q;
    logic signed [CHAIN_W-1:0] c2_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [CHAIN_W-1:0] acc_q;
    logic signed [CHAIN_W-1:0] acc_d;
    logic signed [CHAIN_W-1:0] res_q;
    logic signed [CHAIN_W-1:0] res_d;
    logic                      sat_q;
    logic                      sat_d;
    logic signed [EXT_W-1:0]   prod_ext_s;
    logic signed [EXT_W-1:0]   chain_ext_s;
    logic signed [EXT_W-1:0]   acc_ext_s;
    logic signed [EXT_W-1:0]   sum_s;
    logic [CHAIN_W:0]          red_s;

    // S1 operand capture and S2 product with delayed chain-in.
    always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
        a1_q   <= '0;
        b1_q   <= '0;
        c1_q   <= '0;
        c2_q   <= '0;
        prod_q <= '0;
      end else if (ena) begin
        a1_q   <= mult_a[l*DATA_W +: DATA_W];
        b1_q   <= mult_b[l*DATA_W +: DATA_W];
        c1_q   <= chainin[l*CHAIN_W +: CHAIN_W];
        c2_q   <= c1_q;
        prod_q <= PROD_W'(a1_q) * PROD_W'(b1_q);
      end
    end

    // S3 add/sub at extended width, then reduction; bubbles leave state untouched.
    always_comb begin
      prod_ext_s  = EXT_W'(prod_q);
      chain_ext_s = EXT_W'(c2_q);
      acc_ext_s   = EXT_W'(acc_q);
      case (mode2_q)
        2'b00:   sum_s = chain_ext_s - prod_ext_s;
        2'b01:   sum_s = prod_ext_s - chain_ext_s;
        2'b10:   sum_s = acc_ext_s - prod_ext_s;
        2'b11:   sum_s = chain_ext_s - prod_ext_s;
        default: sum_s = chain_ext_s - prod_ext_s;
      endcase
      red_s = reduce_f(sum_s);
      acc_d = acc_q;
      res_d = res_q;
      sat_d = sat_q;
      if (v2_q) begin
        res_d = red_s[CHAIN_W-1:0];
        sat_d = red_s[CHAIN_W];
        if (mode2_q[1]) begin
          acc_d = red_s[CHAIN_W-1:0];
        end else begin
          acc_d = acc_q;
        end
      end else begin
        res_d = res_q;
      end
    end

    // S3 registers: accumulator, result and flag.
    always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
        acc_q <= '0;
        res_q <= '0;
        sat_q <= 1'b0;
      end else if (ena) begin
        acc_q <= acc_d;
        res_q <= res_d;
        sat_q <= sat_d;
      end
    end

    assign result[l*CHAIN_W +: CHAIN_W] = res_q;
    assign sat_flag[l]                  = sat_q;
  end

endmodule

// File: tb/tb_multsub_ci_pipe.sv
// Directed bench for multsub_ci_pipe: a saturating and a wrapping instance share stimulus.
module tb_multsub_ci_pipe;

  localparam int DW = 18;
  localparam int CW = 48;
  localparam int LN = 4;
  localparam logic signed [CW-1:0] MAXV = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {1'b1, {(CW-1){1'b0}}};

  logic              clk = 1'b0;
  logic              clr_n;
  logic              ena;
  logic              in_valid;
  logic [1:0]        mode;
  logic [LN*DW-1:0]  mult_a;
  logic [LN*DW-1:0]  mult_b;
  logic [LN*CW-1:0]  chainin;
  logic              ov_s, ov_w;
  logic [LN*CW-1:0]  res_s, res_w;
  logic [LN-1:0]     sat_s, sat_w;
  int                pass_cnt = 0;
  int                total_cnt = 0;

  always #5 clk = ~clk;

  multsub_ci_pipe #(.DATA_W(DW), .CHAIN_W(CW), .LANES(LN), .SAT_EN(1)) dut_s (
    .clk(clk), .clr_n(clr_n), .ena(ena), .in_valid(in_valid), .mode(mode),
    .mult_a(mult_a), .mult_b(mult_b), .chainin(chainin),
    .out_valid(ov_s), .result(res_s), .sat_flag(sat_s));

  multsub_ci_pipe #(.DATA_W(DW), .CHAIN_W(CW), .LANES(LN), .SAT_EN(0)) dut_w (
    .clk(clk), .clr_n(clr_n), .ena(ena), .in_valid(in_valid), .mode(mode),
    .mult_a(mult_a), .mult_b(mult_b), .chainin(chainin),
    .out_valid(ov_w), .result(res_w), .sat_flag(sat_w));

  function automatic logic signed [CW-1:0] lane_s(input int l);
    return res_s[l*CW +: CW];
  endfunction

  function automatic logic signed [CW-1:0] lane_w(input int l);
    return res_w[l*CW +: CW];
  endfunction

  task automatic set_lane(input int l, input logic signed [DW-1:0] a,
                          input logic signed [DW-1:0] b, input logic signed [CW-1:0] c);
    mult_a[l*DW +: DW]  = a;
    mult_b[l*DW +: DW]  = b;
    chainin[l*CW +: CW] = c;
  endtask

  task automatic clear_ops;
    mult_a  = '0;
    mult_b  = '0;
    chainin = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0; ena = 1'b1; in_valid = 1'b0; mode = 2'b00;
    clear_ops();
    #12;
    total_cnt++; if (ov_s !== 1'b0) $display("FAIL reset_ov got %0b exp 0", ov_s); else pass_cnt++;
    total_cnt++; if (res_s !== '0 || res_w !== '0) $display("FAIL reset_res got %0h/%0h exp 0", res_s, res_w); else pass_cnt++;
    total_cnt++; if (sat_s !== 4'b0000) $display("FAIL reset_sat got %0b exp 0", sat_s); else pass_cnt++;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_basic;
    clear_ops();
    set_lane(0, 18'sd3, -18'sd4, 48'sd100);
    mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++; if (ov_s !== 1'b0) $display("FAIL lat_edge1 got %0b exp 0", ov_s); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b0) $display("FAIL lat_edge2 got %0b exp 0", ov_s); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b1 || ov_w !== 1'b1) $display("FAIL lat_edge3 got %0b/%0b exp 1", ov_s, ov_w); else pass_cnt++;
    total_cnt++; if (lane_s(0) !== 48'sd112 || lane_w(0) !== 48'sd112) $display("FAIL mode00_res got %0d/%0d exp 112", lane_s(0), lane_w(0)); else pass_cnt++;
    total_cnt++; if (sat_s !== 4'b0000) $display("FAIL mode00_sat got %0b exp 0", sat_s); else pass_cnt++;
    set_lane(0, 18'sd3, 18'sd4, 48'sd5);
    mode = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd7) $display("FAIL mode01_res got %0b/%0d exp 1/7", ov_s, lane_s(0)); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    clear_ops();
    set_lane(0, 18'sd2, 18'sd5, 48'sd50);
    mode = 2'b11; in_valid = 1'b1;
    step();
    mode = 2'b10;
    set_lane(0, 18'sd1, 18'sd10, 48'sd999);
    step(); step();
    in_valid = 1'b0;
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd40) $display("FAIL b2b_load got %0b/%0d exp 1/40", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd30) $display("FAIL b2b_acc1 got %0b/%0d exp 1/30", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd20) $display("FAIL b2b_acc2 got %0b/%0d exp 1/20", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b0 || lane_s(0) !== 48'sd20) $display("FAIL b2b_hold got %0b/%0d exp 0/20", ov_s, lane_s(0)); else pass_cnt++;
  endtask

  task automatic test_sat;
    clear_ops();
    set_lane(0, -18'sd1, 18'sd1, MAXV);
    mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total_cnt++; if (lane_s(0) !== MAXV || sat_s[0] !== 1'b1) $display("FAIL sat_pos got %0d/%0b exp %0d/1", lane_s(0), sat_s[0], MAXV); else pass_cnt++;
    total_cnt++; if (lane_w(0) !== MINV || sat_w[0] !== 1'b1) $display("FAIL wrap_pos got %0d/%0b exp %0d/1", lane_w(0), sat_w[0], MINV); else pass_cnt++;
    set_lane(0, 18'sd1, 18'sd1, MINV);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total_cnt++; if (lane_s(0) !== MINV || sat_s[0] !== 1'b1) $display("FAIL sat_neg got %0d/%0b exp %0d/1", lane_s(0), sat_s[0], MINV); else pass_cnt++;
    total_cnt++; if (lane_w(0) !== MAXV || sat_w[0] !== 1'b1) $display("FAIL wrap_neg got %0d/%0b exp %0d/1", lane_w(0), sat_w[0], MAXV); else pass_cnt++;
  endtask

  task automatic test_lanes;
    clear_ops();
    set_lane(0, 18'sd7, 18'sd6, 48'sd0);
    set_lane(1, -18'sd100, 18'sd200, 48'sd1000);
    set_lane(2, -18'sd1, 18'sd1, MAXV);
    set_lane(3, 18'sd131071, 18'h20000, 48'sd0);
    mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total_cnt++; if (sat_s !== 4'b0100 || sat_w !== 4'b0100) $display("FAIL lanes_sat got %0b/%0b exp 0100", sat_s, sat_w); else pass_cnt++;
    total_cnt++; if (lane_s(0) !== -48'sd42) $display("FAIL lane0 got %0d exp -42", lane_s(0)); else pass_cnt++;
    total_cnt++; if (lane_s(1) !== 48'sd21000) $display("FAIL lane1 got %0d exp 21000", lane_s(1)); else pass_cnt++;
    total_cnt++; if (lane_s(2) !== MAXV || lane_w(2) !== MINV) $display("FAIL lane2 got %0d/%0d", lane_s(2), lane_w(2)); else pass_cnt++;
    total_cnt++; if (lane_s(3) !== 48'sd17179738112) $display("FAIL lane3 got %0d exp 17179738112", lane_s(3)); else pass_cnt++;
  endtask

  task automatic test_ena;
    clear_ops();
    mode = 2'b00; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_lane(0, 18'sd1, 18'(k), 48'sd100);
      step();
    end
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd99) $display("FAIL ena_first got %0b/%0d exp 1/99", ov_s, lane_s(0)); else pass_cnt++;
    ena = 1'b0;
    set_lane(0, 18'sd1, 18'sd4, 48'sd100);
    for (int k = 0; k < 5; k++) begin
      step();
      total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd99) $display("FAIL ena_freeze%0d got %0b/%0d exp 1/99", k, ov_s, lane_s(0)); else pass_cnt++;
    end
    ena = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd98) $display("FAIL ena_e2 got %0b/%0d exp 1/98", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd97) $display("FAIL ena_e3 got %0b/%0d exp 1/97", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd96) $display("FAIL ena_e4 got %0b/%0d exp 1/96", ov_s, lane_s(0)); else pass_cnt++;
    step();
    total_cnt++; if (ov_s !== 1'b0 || lane_s(0) !== 48'sd96) $display("FAIL ena_end got %0b/%0d exp 0/96", ov_s, lane_s(0)); else pass_cnt++;
  endtask

  task automatic test_clr_in_flight;
    clear_ops();
    set_lane(0, 18'sd1, 18'sd23, 48'sd100);
    mode = 2'b11; in_valid = 1'b1;
    step();
    mode = 2'b10;
    set_lane(0, 18'sd1, 18'sd1, 48'sd0);
    step(); step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== 48'sd77) $display("FAIL clr_pre got %0b/%0d exp 1/77", ov_s, lane_s(0)); else pass_cnt++;
    #2;
    clr_n = 1'b0;
    #1;
    total_cnt++; if (ov_s !== 1'b0 || ov_w !== 1'b0) $display("FAIL clr_ov got %0b/%0b exp 0", ov_s, ov_w); else pass_cnt++;
    total_cnt++; if (res_s !== '0 || sat_s !== 4'b0000) $display("FAIL clr_res got %0d/%0b exp 0/0", lane_s(0), sat_s); else pass_cnt++;
    in_valid = 1'b0;
    step(); step();
    clr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total_cnt++; if (ov_s !== 1'b0) $display("FAIL clr_stale%0d got %0b exp 0", k, ov_s); else pass_cnt++;
    end
    set_lane(0, 18'sd1, 18'sd5, 48'sd0);
    mode = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total_cnt++; if (ov_s !== 1'b1 || lane_s(0) !== -48'sd5) $display("FAIL clr_acc got %0b/%0d exp 1/-5", ov_s, lane_s(0)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sat();
    test_lanes();
    test_ena();
    test_clr_in_flight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
